// File: rtl/spi_tx_arbiter.sv
`timescale 1ns/1ps
// spi_tx_arbiter
// Shares one SPI transmit port between two requesters: port 0 (CPU/AHB write
// path) and port 1 (heartbeat sample stream). Requests are granted round-robin.
// Each grant sends one SPI mode-0 frame, MSB first, framed by CS_N.
//
// Ports
//   ahbCLK              system clock, all logic on posedge
//   resetN              asynchronous active-low reset
//   en                  1 = new grants allowed; an in-flight frame always completes
//   req0_valid/data     port 0 request word
//   req0_ready          port 0 word accepted this cycle (combinational)
//   req1_valid/data     port 1 request word
//   req1_ready          port 1 word accepted this cycle (combinational)
//   SCLK, MOSI, CS_N    SPI pins (SCLK idle low, MOSI changes on falling SCLK)
//   busy                1 whenever the sequencer is not idle
//   done                1-cycle pulse in the first CS_N-high cycle after a frame
//   done_id             port served by the frame flagged by done, held until next done
//
// Handshake: a word transfers on the rising clock edge where reqN_valid and
// reqN_ready are both high. readyN is high only while idle, enabled, out of
// reset, and port N is the arbitration winner, so at most one ready is high in
// any cycle. A requester must hold its data stable while valid is high and
// ready is low; a valid that drops before ready is simply forgotten.

module spi_tx_arbiter #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic              ahbCLK,
  input  logic              resetN,
  input  logic              en,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              SCLK,
  output logic              MOSI,
  output logic              CS_N,
  output logic              busy,
  output logic              done,
  output logic              done_id
);

  // One counter serves both the SCLK half-periods and the CS gap, so it is
  // sized for the larger of the two.
  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BW      = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(CS_GAP - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bitcnt;
  logic [DATA_W-1:0] shreg;
  logic              sclk_q;
  logic              last_grant;
  logic              cur_id;
  logic              done_id_q;

  logic grant;
  logic accept;
  logic half_end;
  logic fall_edge;
  logic frame_active;

  // Both valid -> the port that did not win last time; otherwise the only
  // valid port. When neither is valid the value is unused.
  assign grant  = (req0_valid && req1_valid) ? ~last_grant : ~req0_valid;
  assign accept = resetN && en && (state == IDLE) && (req0_valid || req1_valid);

  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;

  assign half_end  = (cnt == DIV_LAST);
  // Falling SCLK edge: end of a high half-period while shifting.
  assign fall_edge = (state == SHIFT) && half_end && sclk_q;

  assign frame_active = (state == SETUP) || (state == SHIFT) || (state == HOLD);

  assign SCLK    = sclk_q;
  assign CS_N    = !frame_active;
  assign MOSI    = frame_active && shreg[DATA_W-1];
  assign busy    = (state != IDLE);
  assign done    = (state == GAP) && (cnt == '0);
  assign done_id = done_id_q;

  // State register
  always_ff @(posedge ahbCLK or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = SETUP;
      SETUP: if (half_end) state_next = SHIFT;
      SHIFT: if (fall_edge && (bitcnt == BIT_LAST)) state_next = HOLD;
      HOLD:  if (half_end) state_next = GAP;
      GAP:   if (cnt == GAP_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: counters, shift register, SCLK, arbitration history
  always_ff @(posedge ahbCLK or negedge resetN) begin
    if (!resetN) begin
      cnt        <= '0;
      bitcnt     <= '0;
      shreg      <= '0;
      sclk_q     <= 1'b0;
      last_grant <= 1'b1;
      cur_id     <= 1'b0;
      done_id_q  <= 1'b0;
    end else begin
      // cnt restarts on every state change and on every SCLK half-period.
      if ((state == IDLE) || (state_next != state)) begin
        cnt <= '0;
      end else if ((state == SHIFT) && half_end) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (accept) begin
        shreg      <= grant ? req1_data : req0_data;
        bitcnt     <= '0;
        last_grant <= grant;
        cur_id     <= grant;
      end else if (fall_edge) begin
        // Zero fill leaves MOSI low once the last bit has gone out.
        shreg <= {shreg[DATA_W-2:0], 1'b0};
        if (bitcnt != BIT_LAST) begin
          bitcnt <= bitcnt + 1'b1;
        end
      end

      if ((state == SHIFT) && half_end) begin
        sclk_q <= ~sclk_q;
      end else if (state != SHIFT) begin
        sclk_q <= 1'b0;
      end

      if ((state == HOLD) && (state_next == GAP)) begin
        done_id_q <= cur_id;
      end
    end
  end

endmodule
